// File: rtl/instr_encoder.sv
// Generic FIFO used for the encoder output buffer.
// Data appears at the head one cycle after a push. Pushes are dropped when full; the caller gates with occupancy.
`ifndef INSTR_ENCODER_DEFS
`define INSTR_ENCODER_DEFS
`define OPCODE_WIDTH 6
`define FUNCT_WIDTH 6
`endif

module enc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic          head_vld,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] occupancy
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign push     = push_vld && (occupancy < CW'(DEPTH));
    assign pop      = pop_rdy && (occupancy != '0);
    assign head_vld = (occupancy != '0);
    assign head_dat = mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CW'(1);
                2'b01:   occupancy <= occupancy - CW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end
endmodule

// Encodes MIPS field sets into 32-bit words and streams them with sequential addresses to instruction memory.
// Latency 1 cycle accept-to-valid; e_o_ready comes from buffer occupancy only, so memory stalls back up after 2 words.
module instr_encoder #(
    parameter int IWIDTH    = 32,
    parameter int AWIDTH    = 5,
    parameter int IMM_WIDTH = 16,
    parameter int MAWIDTH   = 8
) (
    input  logic                     e_clk,
    input  logic                     e_rst,
    input  logic                     e_i_start,
    input  logic [MAWIDTH-1:0]       e_i_base_addr,
    input  logic                     e_i_valid,
    output logic                     e_o_ready,
    input  logic                     e_i_last,
    input  logic [`OPCODE_WIDTH-1:0] e_i_opcode,
    input  logic [`FUNCT_WIDTH-1:0]  e_i_funct,
    input  logic [AWIDTH-1:0]        e_i_addr_rs,
    input  logic [AWIDTH-1:0]        e_i_addr_rt,
    input  logic [AWIDTH-1:0]        e_i_addr_rd,
    input  logic [IMM_WIDTH-1:0]     e_i_imm,
    output logic                     e_o_valid,
    input  logic                     e_i_mem_ready,
    output logic [IWIDTH-1:0]        e_o_instr,
    output logic [MAWIDTH-1:0]       e_o_addr,
    output logic [MAWIDTH:0]         e_o_count,
    output logic                     e_o_err,
    output logic                     e_o_done
);
    localparam logic [`OPCODE_WIDTH-1:0] OP_RTYPE  = 6'h00;
    localparam logic [`OPCODE_WIDTH-1:0] OP_LOAD   = 6'h23;
    localparam logic [`OPCODE_WIDTH-1:0] OP_STORE  = 6'h2B;
    localparam logic [`OPCODE_WIDTH-1:0] OP_BRANCH = 6'h04;
    localparam logic [`FUNCT_WIDTH-1:0]  F_ADD = 6'h20;
    localparam logic [`FUNCT_WIDTH-1:0]  F_SUB = 6'h22;
    localparam logic [`FUNCT_WIDTH-1:0]  F_AND = 6'h24;
    localparam logic [`FUNCT_WIDTH-1:0]  F_OR  = 6'h25;
    localparam logic [`FUNCT_WIDTH-1:0]  F_XOR = 6'h26;
    localparam int DW = MAWIDTH + IWIDTH;
    localparam int CW = 2;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [MAWIDTH-1:0] wr_addr;
    logic [IWIDTH-1:0]  enc_word;
    logic               enc_bad;
    logic               accept;
    logic               pop;
    logic               head_vld;
    logic [DW-1:0]      head_dat;
    logic [CW-1:0]      occupancy;

    assign e_o_ready = (state == ACTIVE) && (occupancy < CW'(2));
    assign accept    = e_i_valid && e_o_ready;
    assign pop       = head_vld && e_i_mem_ready;
    assign e_o_valid = head_vld;
    // Outputs read as zero while the buffer is empty so reset leaves every output at 0.
    assign e_o_instr = head_vld ? head_dat[IWIDTH-1:0] : '0;
    assign e_o_addr  = head_vld ? head_dat[DW-1:IWIDTH] : '0;

    always_comb begin
        enc_word = '0;
        enc_bad  = 1'b0;
        case (e_i_opcode)
            OP_RTYPE: begin
                if (e_i_funct == F_ADD || e_i_funct == F_SUB || e_i_funct == F_AND ||
                    e_i_funct == F_OR  || e_i_funct == F_XOR) begin
                    enc_word = IWIDTH'({e_i_opcode, e_i_addr_rs, e_i_addr_rt, e_i_addr_rd,
                                        5'b0, e_i_funct});
                end else begin
                    enc_bad = 1'b1;
                end
            end
            OP_LOAD, OP_STORE, OP_BRANCH: begin
                enc_word = IWIDTH'({e_i_opcode, e_i_addr_rs, e_i_addr_rt, e_i_imm});
            end
            default: enc_bad = 1'b1;
        endcase
    end

    enc_fifo #(.W(DW), .DEPTH(2)) u_out_buf (
        .clk       (e_clk),
        .rst       (e_rst),
        .push_vld  (accept),
        .push_dat  ({wr_addr, enc_word}),
        .pop_rdy   (e_i_mem_ready),
        .head_vld  (head_vld),
        .head_dat  (head_dat),
        .occupancy (occupancy)
    );

    always_ff @(posedge e_clk or posedge e_rst) begin
        if (e_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        e_o_done  = 1'b0;
        case (state)
            IDLE: begin
                if (e_i_start) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (accept && e_i_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (occupancy == '0) begin
                    e_o_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge e_clk or posedge e_rst) begin
        if (e_rst) begin
            wr_addr   <= '0;
            e_o_count <= '0;
            e_o_err   <= 1'b0;
        end else if (state == IDLE && e_i_start) begin
            wr_addr   <= e_i_base_addr;
            e_o_count <= '0;
            e_o_err   <= 1'b0;
        end else begin
            if (accept) begin
                wr_addr <= wr_addr + MAWIDTH'(1);
                if (enc_bad) begin
                    e_o_err <= 1'b1;
                end
            end
            if (pop) begin
                e_o_count <= e_o_count + (MAWIDTH+1)'(1);
            end
        end
    end
endmodule
